mem_wb_writeback: RTL and testbench

- Writer side of the register file write port. Implements the MEM/WB pipeline register, load-data alignment and sign/zero extension, and the writeback result mux.
- Drives Write_Reg_Num, Write_Data and RegWrite_mm_wb straight into the register file.
- Handles stall and flush from the hazard unit, blocks writes to r0 and on misaligned loads, and counts retired instructions.

---
 rtl/mem_wb_writeback.sv | 209 ++++++++++++++++++++
 tb/tb_mem_wb_writeback.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_writeback.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_writeback
// Brief    : MEM/WB pipeline register, big-endian load alignment with
//            sign/zero extension, writeback mux and retired-instruction
//            counter. Drives the register-file write port directly.
//            Optional macro WB_FWD_EN adds registered copies of the last
//            performed write (fwd_valid / fwd_reg / fwd_data).
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_writeback #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic              mem_RegWrite,
  input  logic              mem_MemtoReg,
  input  logic [1:0]        mem_load_size,
  input  logic              mem_load_unsigned,
  input  logic [1:0]        mem_addr_lo,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [REG_AW-1:0] mem_dest_reg,
  input  logic              stall,
  input  logic              flush,
  output logic [REG_AW-1:0] Write_Reg_Num,
  output logic [DATA_W-1:0] Write_Data,
  output logic              RegWrite_mm_wb,
  output logic              wb_valid,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  retire_count
`ifdef WB_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_reg,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  localparam logic [1:0] c_size_byte = 2'b00;
  localparam logic [1:0] c_size_half = 2'b01;

  // WB register fields
  logic              valid_q, valid_d;
  logic              regwrite_q, regwrite_d;
  logic              memtoreg_q, memtoreg_d;
  logic [1:0]        load_size_q, load_size_d;
  logic              load_unsigned_q, load_unsigned_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic [DATA_W-1:0] alu_result_q, alu_result_d;
  logic [REG_AW-1:0] dest_q, dest_d;
  logic              retired_q, retired_d;
  logic [CNT_W-1:0]  retire_count_q, retire_count_d;

  logic              w_misaligned;
  logic              w_retire_now;
  logic              w_write_en;
  logic [7:0]        w_byte_sel;
  logic [15:0]       w_half_sel;
  logic [DATA_W-1:0] w_load_data;

  // The instruction in WB acts only on its first cycle there; a held stall
  // must not repeat the write or the count.
  assign w_retire_now = valid_q & ~retired_q;

  // Half needs 2-byte alignment; word (and reserved size) needs 4-byte.
  assign w_misaligned = memtoreg_q &
                        (((load_size_q == c_size_half) & addr_lo_q[0]) |
                         (load_size_q[1] & (addr_lo_q != 2'b00)));

  assign w_write_en = w_retire_now & regwrite_q & (dest_q != '0) & ~w_misaligned;

  // Next-state for the WB register: flush beats stall beats load
  always_comb begin
    valid_d         = valid_q;
    regwrite_d      = regwrite_q;
    memtoreg_d      = memtoreg_q;
    load_size_d     = load_size_q;
    load_unsigned_d = load_unsigned_q;
    addr_lo_d       = addr_lo_q;
    read_data_d     = read_data_q;
    alu_result_d    = alu_result_q;
    dest_d          = dest_q;
    retired_d       = retired_q;
    if (flush) begin
      valid_d         = 1'b0;
      regwrite_d      = 1'b0;
      memtoreg_d      = 1'b0;
      load_size_d     = 2'b00;
      load_unsigned_d = 1'b0;
      addr_lo_d       = 2'b00;
      read_data_d     = '0;
      alu_result_d    = '0;
      dest_d          = '0;
      retired_d       = 1'b0;
    end else if (stall) begin
      retired_d       = retired_q | valid_q;
    end else begin
      valid_d         = mem_valid;
      regwrite_d      = mem_RegWrite;
      memtoreg_d      = mem_MemtoReg;
      load_size_d     = mem_load_size;
      load_unsigned_d = mem_load_unsigned;
      addr_lo_d       = mem_addr_lo;
      read_data_d     = mem_read_data;
      alu_result_d    = mem_alu_result;
      dest_d          = mem_dest_reg;
      retired_d       = 1'b0;
    end
    retire_count_d = retire_count_q + {{(CNT_W-1){1'b0}}, w_retire_now};
  end

  // WB register and retire counter
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q         <= 1'b0;
      regwrite_q      <= 1'b0;
      memtoreg_q      <= 1'b0;
      load_size_q     <= 2'b00;
      load_unsigned_q <= 1'b0;
      addr_lo_q       <= 2'b00;
      read_data_q     <= '0;
      alu_result_q    <= '0;
      dest_q          <= '0;
      retired_q       <= 1'b0;
      retire_count_q  <= '0;
    end else begin
      valid_q         <= valid_d;
      regwrite_q      <= regwrite_d;
      memtoreg_q      <= memtoreg_d;
      load_size_q     <= load_size_d;
      load_unsigned_q <= load_unsigned_d;
      addr_lo_q       <= addr_lo_d;
      read_data_q     <= read_data_d;
      alu_result_q    <= alu_result_d;
      dest_q          <= dest_d;
      retired_q       <= retired_d;
      retire_count_q  <= retire_count_d;
    end
  end

  // Big-endian lane select and extension of the loaded word
  always_comb begin
    case (addr_lo_q)
      2'd0:    w_byte_sel = read_data_q[31:24];
      2'd1:    w_byte_sel = read_data_q[23:16];
      2'd2:    w_byte_sel = read_data_q[15:8];
      default: w_byte_sel = read_data_q[7:0];
    endcase
    w_half_sel = addr_lo_q[1] ? read_data_q[15:0] : read_data_q[31:16];
    case (load_size_q)
      c_size_byte: w_load_data = load_unsigned_q ?
                                 {{(DATA_W-8){1'b0}}, w_byte_sel} :
                                 {{(DATA_W-8){w_byte_sel[7]}}, w_byte_sel};
      c_size_half: w_load_data = load_unsigned_q ?
                                 {{(DATA_W-16){1'b0}}, w_half_sel} :
                                 {{(DATA_W-16){w_half_sel[15]}}, w_half_sel};
      default:     w_load_data = read_data_q;
    endcase
  end

  assign Write_Reg_Num  = dest_q;
  assign Write_Data     = memtoreg_q ? w_load_data : alu_result_q;
  assign RegWrite_mm_wb = w_write_en;
  assign wb_valid       = valid_q;
  assign misalign_err   = w_retire_now & w_misaligned;
  assign retire_count   = retire_count_q;

`ifdef WB_FWD_EN
  logic              fwd_valid_q, fwd_valid_d;
  logic [REG_AW-1:0] fwd_reg_q, fwd_reg_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;

  // Capture each performed write; hold it until the next one
  always_comb begin
    fwd_valid_d = fwd_valid_q;
    fwd_reg_d   = fwd_reg_q;
    fwd_data_d  = fwd_data_q;
    if (w_write_en) begin
      fwd_valid_d = 1'b1;
      fwd_reg_d   = dest_q;
      fwd_data_d  = Write_Data;
    end
  end

  // Forwarding copy registers
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_valid_q <= 1'b0;
      fwd_reg_q   <= '0;
      fwd_data_q  <= '0;
    end else begin
      fwd_valid_q <= fwd_valid_d;
      fwd_reg_q   <= fwd_reg_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

  assign fwd_valid = fwd_valid_q;
  assign fwd_reg   = fwd_reg_q;
  assign fwd_data  = fwd_data_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_writeback
// Brief    : Self-checking bench for mem_wb_writeback. A behavioural model of
//            the instruction sitting in WB predicts every output each cycle;
//            directed steps add hand-computed literal expectations.
//            Honours WB_FWD_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wb_writeback;

  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid, mem_RegWrite, mem_MemtoReg, mem_load_unsigned;
  logic [1:0]  mem_load_size, mem_addr_lo;
  logic [31:0] mem_read_data, mem_alu_result;
  logic [4:0]  mem_dest_reg;
  logic        stall, flush;
  logic [4:0]  Write_Reg_Num;
  logic [31:0] Write_Data;
  logic        RegWrite_mm_wb, wb_valid, misalign_err;
  logic [CNT_W-1:0] retire_count;
`ifdef WB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_wb_writeback #(.DATA_W(32), .REG_AW(5), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .mem_valid        (mem_valid),
    .mem_RegWrite     (mem_RegWrite),
    .mem_MemtoReg     (mem_MemtoReg),
    .mem_load_size    (mem_load_size),
    .mem_load_unsigned(mem_load_unsigned),
    .mem_addr_lo      (mem_addr_lo),
    .mem_read_data    (mem_read_data),
    .mem_alu_result   (mem_alu_result),
    .mem_dest_reg     (mem_dest_reg),
    .stall            (stall),
    .flush            (flush),
    .Write_Reg_Num    (Write_Reg_Num),
    .Write_Data       (Write_Data),
    .RegWrite_mm_wb   (RegWrite_mm_wb),
    .wb_valid         (wb_valid),
    .misalign_err     (misalign_err),
    .retire_count     (retire_count)
`ifdef WB_FWD_EN
    ,
    .fwd_valid        (fwd_valid),
    .fwd_reg          (fwd_reg),
    .fwd_data         (fwd_data)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the WB slot ----------------
  bit          m_live = 1'b0;
  logic        m_v, m_rw, m_m2r, m_uns;
  logic [1:0]  m_sz, m_a;
  logic [31:0] m_rd, m_alu;
  logic [4:0]  m_dst;
  bit          m_written;
  int          m_retired_total;
  logic        m_fv;
  logic [4:0]  m_fr;
  logic [31:0] m_fd;

  function automatic bit exp_misal();
    if (!m_m2r) return 1'b0;
    if (m_sz == 2'd1) return (m_a % 2) == 1;
    if (m_sz >= 2'd2) return m_a != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_data();
    logic [7:0]  b [4];
    logic [7:0]  bv;
    logic [15:0] hv;
    if (!m_m2r) return m_alu;
    b[0] = m_rd[31:24]; b[1] = m_rd[23:16]; b[2] = m_rd[15:8]; b[3] = m_rd[7:0];
    if (m_sz == 2'd0) begin
      bv = b[m_a];
      return m_uns ? {24'd0, bv} : {{24{bv[7]}}, bv};
    end
    if (m_sz == 2'd1) begin
      hv = (m_a >= 2) ? {b[2], b[3]} : {b[0], b[1]};
      return m_uns ? {16'd0, hv} : {{16{hv[15]}}, hv};
    end
    return m_rd;
  endfunction

  function automatic bit exp_we();
    return m_v && m_rw && (m_dst != 0) && !exp_misal() && !m_written;
  endfunction

  function automatic bit exp_err();
    return m_v && m_m2r && exp_misal() && !m_written;
  endfunction

  // Model update on each clock edge
  always @(posedge clk) begin
    if (reset) begin
      m_live <= 1'b1;
      m_v <= 0; m_rw <= 0; m_m2r <= 0; m_uns <= 0; m_sz <= 0; m_a <= 0;
      m_rd <= 0; m_alu <= 0; m_dst <= 0; m_written <= 0; m_retired_total <= 0;
      m_fv <= 0; m_fr <= 0; m_fd <= 0;
    end else if (m_live) begin
      if (exp_we()) begin
        m_fv <= 1'b1; m_fr <= m_dst; m_fd <= exp_data();
      end
      if (m_v && !m_written) m_retired_total <= m_retired_total + 1;
      if (flush) begin
        m_v <= 0; m_rw <= 0; m_m2r <= 0; m_uns <= 0; m_sz <= 0; m_a <= 0;
        m_rd <= 0; m_alu <= 0; m_dst <= 0; m_written <= 0;
      end else if (stall) begin
        m_written <= m_written | m_v;
      end else begin
        m_v <= mem_valid; m_rw <= mem_RegWrite; m_m2r <= mem_MemtoReg;
        m_uns <= mem_load_unsigned; m_sz <= mem_load_size; m_a <= mem_addr_lo;
        m_rd <= mem_read_data; m_alu <= mem_alu_result; m_dst <= mem_dest_reg;
        m_written <= 0;
      end
    end
  end

  // Compare DUT against model mid-cycle
  always @(negedge clk) begin
    if (m_live) begin
      chk("cmp_wb_valid", {31'd0, wb_valid}, {31'd0, m_v});
      chk("cmp_reg_num", {27'd0, Write_Reg_Num}, {27'd0, m_dst});
      chk("cmp_data", Write_Data, exp_data());
      chk("cmp_we", {31'd0, RegWrite_mm_wb}, {31'd0, exp_we()});
      chk("cmp_misalign", {31'd0, misalign_err}, {31'd0, exp_err()});
      chk("cmp_count", {28'd0, retire_count}, m_retired_total % (1 << CNT_W));
`ifdef WB_FWD_EN
      chk("cmp_fwd_valid", {31'd0, fwd_valid}, {31'd0, m_fv});
      chk("cmp_fwd_reg", {27'd0, fwd_reg}, {27'd0, m_fr});
      chk("cmp_fwd_data", fwd_data, m_fd);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic put(input logic v, input logic rw, input logic m2r,
                     input logic [1:0] sz, input logic uns, input logic [1:0] a,
                     input logic [31:0] rd, input logic [31:0] alu, input logic [4:0] d);
    mem_valid = v; mem_RegWrite = rw; mem_MemtoReg = m2r; mem_load_size = sz;
    mem_load_unsigned = uns; mem_addr_lo = a; mem_read_data = rd;
    mem_alu_result = alu; mem_dest_reg = d;
  endtask

  task automatic idle();
    put(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    idle();
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_we", {31'd0, RegWrite_mm_wb}, 32'd0);
    chk("rst_data", Write_Data, 32'd0);
    chk("rst_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_count", {28'd0, retire_count}, 32'd0);
    chk("rst_regnum", {27'd0, Write_Reg_Num}, 32'd0);

    // ALU result into r5
    put(1, 1, 0, 2'd2, 0, 2'd0, 32'd0, 32'h0000_1234, 5'd5);
    tick();
    chk("alu_regnum", {27'd0, Write_Reg_Num}, 32'd5);
    chk("alu_data", Write_Data, 32'h0000_1234);
    chk("alu_we", {31'd0, RegWrite_mm_wb}, 32'd1);
    // lb signed at addr 1
    put(1, 1, 1, 2'd0, 0, 2'd1, 32'h1280_FF7F, 32'd0, 5'd3);
    tick();
    chk("alu_count", {28'd0, retire_count}, 32'd1);
    chk("lb_data", Write_Data, 32'hFFFF_FF80);
    chk("lb_we", {31'd0, RegWrite_mm_wb}, 32'd1);
    put(1, 1, 1, 2'd0, 1, 2'd2, 32'h1280_FF7F, 32'd0, 5'd3);
    tick();
    chk("lbu_data", Write_Data, 32'h0000_00FF);
    put(1, 1, 1, 2'd1, 1, 2'd2, 32'h1280_FF7F, 32'd0, 5'd4);
    tick();
    chk("lhu_data", Write_Data, 32'h0000_FF7F);
    put(1, 1, 1, 2'd1, 0, 2'd2, 32'h1280_FF7F, 32'd0, 5'd4);
    tick();
    chk("lh_data", Write_Data, 32'hFFFF_FF7F);
    // misaligned lw into r8
    put(1, 1, 1, 2'd2, 0, 2'd2, 32'hCAFE_F00D, 32'd0, 5'd8);
    tick();
    chk("lw_mis_we", {31'd0, RegWrite_mm_wb}, 32'd0);
    chk("lw_mis_err", {31'd0, misalign_err}, 32'd1);
    // ALU into r0: retires but never writes
    put(1, 1, 0, 2'd2, 0, 2'd0, 32'd0, 32'h0000_0077, 5'd0);
    tick();
    chk("r0_err_gone", {31'd0, misalign_err}, 32'd0);
    chk("r0_we", {31'd0, RegWrite_mm_wb}, 32'd0);
    chk("r0_data", Write_Data, 32'h0000_0077);
    chk("count6", {28'd0, retire_count}, 32'd6);
    idle();
    tick();
    chk("count7", {28'd0, retire_count}, 32'd7);

    // Stall held three cycles: single write pulse
    put(1, 1, 0, 2'd2, 0, 2'd0, 32'd0, 32'h0000_0055, 5'd9);
    tick();
    chk("stall_first_we", {31'd0, RegWrite_mm_wb}, 32'd1);
    stall = 1'b1;
    put(1, 1, 0, 2'd2, 0, 2'd0, 32'd0, 32'h0000_00AA, 5'd10);
    tick();
    chk("stall_we_low", {31'd0, RegWrite_mm_wb}, 32'd0);
    chk("stall_held_reg", {27'd0, Write_Reg_Num}, 32'd9);
    chk("stall_held_valid", {31'd0, wb_valid}, 32'd1);
    tick(); tick();
    chk("stall_we_still_low", {31'd0, RegWrite_mm_wb}, 32'd0);
    chk("stall_count", {28'd0, retire_count}, 32'd8);
    flush = 1'b1;
    tick();
    chk("flush_stall_valid", {31'd0, wb_valid}, 32'd0);
    chk("flush_count", {28'd0, retire_count}, 32'd8);
    flush = 1'b0; stall = 1'b0;
    tick();
    chk("after_stall_reg", {27'd0, Write_Reg_Num}, 32'd10);
    chk("after_stall_we", {31'd0, RegWrite_mm_wb}, 32'd1);
    flush = 1'b1;
    tick();
    chk("flush_valid", {31'd0, wb_valid}, 32'd0);
    chk("flush_count9", {28'd0, retire_count}, 32'd9);
    flush = 1'b0;
    idle();

    // Forwarding copy of r7 write
    put(1, 1, 0, 2'd2, 0, 2'd0, 32'd0, 32'hDEAD_BEEF, 5'd7);
    tick();
    idle();
    tick();
`ifdef WB_FWD_EN
    chk("fwd_valid", {31'd0, fwd_valid}, 32'd1);
    chk("fwd_reg", {27'd0, fwd_reg}, 32'd7);
    chk("fwd_data", fwd_data, 32'hDEAD_BEEF);
`endif
    chk("count10", {28'd0, retire_count}, 32'd10);

    // Reset arriving during a stall
    put(1, 1, 0, 2'd2, 0, 2'd0, 32'd0, 32'h0000_0099, 5'd4);
    tick();
    stall = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    chk("mrst_regnum", {27'd0, Write_Reg_Num}, 32'd0);
    chk("mrst_data", Write_Data, 32'd0);
    chk("mrst_we", {31'd0, RegWrite_mm_wb}, 32'd0);
    chk("mrst_valid", {31'd0, wb_valid}, 32'd0);
    chk("mrst_err", {31'd0, misalign_err}, 32'd0);
    chk("mrst_count", {28'd0, retire_count}, 32'd0);
`ifdef WB_FWD_EN
    chk("mrst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    chk("mrst_fwd_data", fwd_data, 32'd0);
`endif
    reset = 1'b0; stall = 1'b0;
    idle();
    tick();

    // Every size x offset x extension combination against the model
    for (int sz = 0; sz < 4; sz++)
      for (int a = 0; a < 4; a++)
        for (int u = 0; u < 2; u++) begin
          put(1, 1, 1, sz[1:0], u[0], a[1:0], $urandom, $urandom,
              5'($urandom_range(0, 31)));
          tick();
        end
    idle();
    tick();
    chk("wrap_count0", {28'd0, retire_count}, 32'd0);

    // Wrap past the counter width once more
    for (int i = 0; i < 17; i++) begin
      put(1, 1, 0, 2'd2, 0, 2'd0, 32'd0, 32'(i), 5'd1);
      tick();
    end
    idle();
    tick();
    chk("wrap_count1", {28'd0, retire_count}, 32'd1);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
